// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file write-port controller.
package regfile_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned NUM_REGS   = 32;

  typedef enum logic {
    StInit,
    StRun
  } state_e;

endpackage

// File: rtl/regfile_ctrl.sv
// Register-file write-port controller: clears x0..x31 after reset, then arbitrates core
// writeback against an optional debug write port (enabled by REGFILE_CTRL_DBG_EN).
module regfile_ctrl
  import regfile_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  core_we,
  input  logic [REG_ADDR_W-1:0] core_a3,
  input  logic [XLEN-1:0]       core_wd,
  input  logic                  dbg_req,
  input  logic [REG_ADDR_W-1:0] dbg_a,
  input  logic [XLEN-1:0]       dbg_wd,
  output logic                  dbg_gnt,
  output logic                  core_stall,
  output logic                  busy,
  output logic                  WE3,
  output logic [REG_ADDR_W-1:0] A3,
  output logic [XLEN-1:0]       WD3
);

  localparam logic [REG_ADDR_W-1:0] LastReg = REG_ADDR_W'(NUM_REGS - 1);

  state_e                state_q, state_d;
  logic [REG_ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

  logic gnt;
  logic force_gnt;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= StInit;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      StInit: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LastReg) begin
          state_d = StRun;
        end
      end
      StRun: begin
        state_d = StRun;
      end
    endcase
  end

`ifdef REGFILE_CTRL_DBG_EN
  localparam logic [3:0] StarveLim = 4'(STARVE_LIMIT);

  logic [3:0] starve_q, starve_d;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  // Force the debug write through once it has waited STARVE_LIMIT cycles.
  assign force_gnt = (state_q == StRun) && dbg_req && (starve_q == StarveLim);
  assign gnt       = (state_q == StRun) && dbg_req && (!core_we || force_gnt);

  always_comb begin
    starve_d = starve_q;
    if ((state_q != StRun) || !dbg_req || gnt) begin
      starve_d = '0;
    end else if (starve_q != 4'hF) begin
      starve_d = starve_q + 4'd1;
    end
  end
`else
  logic [3:0]                         unused_starve_lim;
  logic [XLEN+REG_ADDR_W:0]           unused_dbg;

  assign unused_starve_lim = 4'(STARVE_LIMIT);
  assign unused_dbg        = {dbg_req, dbg_a, dbg_wd};
  assign force_gnt         = 1'b0;
  assign gnt               = 1'b0;
`endif

  always_comb begin
    WE3        = 1'b0;
    A3         = '0;
    WD3        = '0;
    dbg_gnt    = 1'b0;
    busy       = 1'b0;
    core_stall = 1'b0;
    unique case (state_q)
      StInit: begin
        // Reset holds state in StInit, so the write strobe is gated by RSTn directly.
        WE3        = RSTn;
        A3         = clr_cnt_q;
        busy       = 1'b1;
        core_stall = 1'b1;
      end
      StRun: begin
        if (gnt) begin
          dbg_gnt    = 1'b1;
          core_stall = force_gnt;
          A3         = dbg_a;
          WD3        = dbg_wd;
          WE3        = (dbg_a != '0);
        end else if (core_we) begin
          A3  = core_a3;
          WD3 = core_wd;
          WE3 = (core_a3 != '0);
        end
      end
    endcase
  end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Self-checking bench for regfile_ctrl against a cycle-level behavioural model.
module tb_regfile_ctrl;

  localparam int unsigned StarveLimit = 8;
`ifdef REGFILE_CTRL_DBG_EN
  localparam bit DbgEn = 1'b1;
`else
  localparam bit DbgEn = 1'b0;
`endif

  logic        CLK;
  logic        RSTn;
  logic        core_we;
  logic [4:0]  core_a3;
  logic [31:0] core_wd;
  logic        dbg_req;
  logic [4:0]  dbg_a;
  logic [31:0] dbg_wd;
  logic        dbg_gnt;
  logic        core_stall;
  logic        busy;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;

  int errors = 0;
  int checks = 0;

  // Model: number of clear cycles completed since reset, and cycles the debug request waited.
  int m_clr  = 0;
  int m_wait = 0;
  bit exp_gnt_last = 1'b0;
  bit dut_gnt_seen = 1'b0;

  regfile_ctrl #(
    .STARVE_LIMIT(StarveLimit)
  ) u_dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .core_we   (core_we),
    .core_a3   (core_a3),
    .core_wd   (core_wd),
    .dbg_req   (dbg_req),
    .dbg_a     (dbg_a),
    .dbg_wd    (dbg_wd),
    .dbg_gnt   (dbg_gnt),
    .core_stall(core_stall),
    .busy      (busy),
    .WE3       (WE3),
    .A3        (A3),
    .WD3       (WD3)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called just after a falling edge with inputs already applied; returns after the next one.
  task automatic step(input string tag);
    bit          e_we;
    bit          e_gnt;
    bit          e_stall;
    bit          e_busy;
    bit          forced;
    logic [4:0]  e_a;
    logic [31:0] e_wd;
    e_we    = 1'b0;
    e_gnt   = 1'b0;
    e_stall = 1'b0;
    e_busy  = 1'b0;
    forced  = 1'b0;
    e_a     = '0;
    e_wd    = '0;
    #1;
    if (!RSTn) begin
      e_busy  = 1'b1;
      e_stall = 1'b1;
    end else if (m_clr < 32) begin
      e_we    = 1'b1;
      e_a     = m_clr[4:0];
      e_busy  = 1'b1;
      e_stall = 1'b1;
    end else begin
      forced  = DbgEn && dbg_req && (m_wait == int'(StarveLimit));
      e_gnt   = DbgEn && dbg_req && (!core_we || forced);
      e_stall = forced;
      if (e_gnt) begin
        e_a  = dbg_a;
        e_wd = dbg_wd;
        e_we = (dbg_a != 5'd0);
      end else if (core_we) begin
        e_a  = core_a3;
        e_wd = core_wd;
        e_we = (core_a3 != 5'd0);
      end
    end
    chk({tag, ".we3"}, 32'(WE3), 32'(e_we));
    chk({tag, ".gnt"}, 32'(dbg_gnt), 32'(e_gnt));
    chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
    chk({tag, ".stall"}, 32'(core_stall), 32'(e_stall));
    if (RSTn) begin
      chk({tag, ".a3"}, 32'(A3), 32'(e_a));
      chk({tag, ".wd3"}, WD3, e_wd);
    end
    exp_gnt_last = e_gnt;
    dut_gnt_seen = dbg_gnt;
    @(posedge CLK);
    if (!RSTn) begin
      m_clr  = 0;
      m_wait = 0;
    end else if (m_clr < 32) begin
      m_clr++;
      m_wait = 0;
    end else if (DbgEn && dbg_req && !e_gnt) begin
      m_wait = (m_wait < 15) ? m_wait + 1 : 15;
    end else begin
      m_wait = 0;
    end
    @(negedge CLK);
  endtask

  task automatic rand_inputs();
    core_we = ($urandom_range(0, 9) < 8);
    core_a3 = 5'($urandom_range(0, 31));
    core_wd = $urandom;
    // Debug requests are held stable until the model says they were granted.
    if (!dbg_req || exp_gnt_last) begin
      dbg_req = ($urandom_range(0, 2) == 0);
      dbg_a   = 5'($urandom_range(0, 31));
      dbg_wd  = $urandom;
    end
  endtask

  int first_gnt;

  initial begin
    RSTn    = 1'b0;
    core_we = 1'b1;
    core_a3 = 5'd3;
    core_wd = 32'h1111_2222;
    dbg_req = 1'b1;
    dbg_a   = 5'd4;
    dbg_wd  = 32'h3333_4444;
    @(negedge CLK);

    for (int i = 0; i < 3; i++) step("reset");
    RSTn = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rand_inputs();
      step("clear");
    end

    // Directed RUN cases.
    dbg_req = 1'b0;
    core_we = 1'b1; core_a3 = 5'd5; core_wd = 32'hDEAD_BEEF;
    step("core_wr5");
    core_a3 = 5'd0; core_wd = 32'hFFFF_FFFF;
    step("core_x0");
    core_we = 1'b0; dbg_req = 1'b1; dbg_a = 5'd7; dbg_wd = 32'h12;
    step("idle_gnt");
    dbg_req = 1'b0;
    step("idle");
    dbg_req = 1'b1; dbg_a = 5'd0; dbg_wd = 32'hABCD;
    step("dbg_x0");
    dbg_req = 1'b0;

    // Starvation: core hogs the port while a debug write waits.
    first_gnt = 0;
    core_we = 1'b1; dbg_req = 1'b1; dbg_a = 5'd9; dbg_wd = 32'h5A5A_0009;
    for (int i = 1; i <= 12; i++) begin
      core_a3 = 5'($urandom_range(1, 31));
      core_wd = $urandom;
      step("starve");
      if (dut_gnt_seen && first_gnt == 0) first_gnt = i;
      if (exp_gnt_last) dbg_req = 1'b0;
    end
    chk("starve_cycle", 32'(first_gnt), DbgEn ? 32'd9 : 32'd0);
    dbg_req = 1'b0;

    for (int i = 0; i < 200; i++) begin
      rand_inputs();
      step("rand");
    end

    // Reset pulsed in RUN, then again part-way through the clear.
    RSTn = 1'b0;
    rand_inputs();
    step("rst_run");
    RSTn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rand_inputs();
      step("clear2");
    end
    RSTn = 1'b0;
    step("rst_init");
    step("rst_init");
    RSTn = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rand_inputs();
      step("clear3");
    end
    for (int i = 0; i < 60; i++) begin
      rand_inputs();
      step("rand2");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
